// File: rtl/rtc_multi_alarm_if.sv
// rtl/rtc_multi_alarm_if.sv - set-value, alarm-control and display signal bundle for rtc_multi_alarm
interface rtc_multi_alarm_if #(
  parameter int NUM_ALARMS = 4,
  parameter int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
  logic [1:0]            h_in1;
  logic [3:0]            h_in0;
  logic [2:0]            m_in1;
  logic [3:0]            m_in0;
  logic                  ld_time;
  logic                  ld_alarm;
  logic [AW-1:0]         alarm_sel;
  logic [NUM_ALARMS-1:0] al_en;
  logic                  stop_al;
  logic                  snooze;
  logic                  alarm;
  logic [NUM_ALARMS-1:0] alarm_src;
  logic                  load_err;
  logic                  sec_tick;
  logic [1:0]            h_out1;
  logic [3:0]            h_out0;
  logic [2:0]            m_out1;
  logic [3:0]            m_out0;
  logic [2:0]            s_out1;
  logic [3:0]            s_out0;

  modport master (
    output h_in1, h_in0, m_in1, m_in0, ld_time, ld_alarm, alarm_sel, al_en, stop_al, snooze,
    input  alarm, alarm_src, load_err, sec_tick, h_out1, h_out0, m_out1, m_out0, s_out1, s_out0
  );

  modport slave (
    input  h_in1, h_in0, m_in1, m_in0, ld_time, ld_alarm, alarm_sel, al_en, stop_al, snooze,
    output alarm, alarm_src, load_err, sec_tick, h_out1, h_out0, m_out1, m_out0, s_out1, s_out0
  );
endinterface

// File: rtl/rtc_multi_alarm.sv
// rtl/rtc_multi_alarm.sv - 24h RTC with multi-slot alarms and shared snooze; define ALARM_TIMEOUT_EN for ringing auto-off
module rtc_multi_alarm #(
  parameter int CLK_HZ      = 10,
  parameter int NUM_ALARMS  = 4,
  parameter int SNOOZE_MIN  = 5,
  parameter int TIMEOUT_SEC = 60
) (
  input  logic              clk,
  input  logic              reset,
  rtc_multi_alarm_if.slave  bus
);
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int PW = $clog2(CLK_HZ);
  localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
  localparam logic [PW-1:0] PRESC_MAX    = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SNOOZE_TICKS = SW'(SNOOZE_MIN * 60);
  localparam logic [AW:0]   NUM_SLOTS    = (AW + 1)'(NUM_ALARMS);

  // Out-of-range configurations are stopped at elaboration.
  if (CLK_HZ < 2 || NUM_ALARMS < 1 || NUM_ALARMS > 16 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59 ||
      TIMEOUT_SEC < 1) begin : g_bad_cfg
    $error("rtc_multi_alarm: parameter out of range");
  end

  logic [PW-1:0]              presc_q, presc_d;
  logic [4:0]                 hour_q, hour_d;
  logic [5:0]                 min_q, min_d, sec_q, sec_d;
  logic [NUM_ALARMS-1:0][4:0] al_hour_q, al_hour_d;
  logic [NUM_ALARMS-1:0][5:0] al_min_q, al_min_d;
  logic [NUM_ALARMS-1:0]      src_q, src_d, mask_q, mask_d, trig;
  logic [SW-1:0]              cnt_q, cnt_d;
  logic                       load_err_q, load_err_d;
  logic [5:0]                 set_hour;
  logic [6:0]                 set_min;
  logic                       set_ok, sel_ok, load_time, load_alarm, tick, wrap, expire;

  // Tens digits of the inputs cannot exceed 9 at their widths; only units need a digit check.
  assign set_hour   = 6'(bus.h_in1) * 6'd10 + 6'(bus.h_in0);
  assign set_min    = 7'(bus.m_in1) * 7'd10 + 7'(bus.m_in0);
  assign set_ok     = (bus.h_in0 <= 4'd9) && (bus.m_in0 <= 4'd9) && (set_hour <= 6'd23) && (set_min <= 7'd59);
  assign sel_ok     = {1'b0, bus.alarm_sel} < NUM_SLOTS;
  assign load_time  = bus.ld_time && set_ok;
  assign load_alarm = !bus.ld_time && bus.ld_alarm && set_ok && sel_ok;
  assign load_err_d = (bus.ld_time && !set_ok) || (!bus.ld_time && bus.ld_alarm && !(set_ok && sel_ok));
  assign tick       = (presc_q == PRESC_MAX);
  assign expire     = tick && (cnt_q == SW'(1));

  // Prescaler and time-of-day advance; a valid time load replaces the tick.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    wrap    = 1'b0;
    if (load_time) begin
      presc_d = '0;
      hour_d  = set_hour[4:0];
      min_d   = set_min[5:0];
      sec_d   = '0;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        wrap  = 1'b1;
        if (min_q == 6'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Alarm slot writes and minute-boundary match against the pre-load slot contents.
  always_comb begin
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    trig      = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      trig[i] = wrap && bus.al_en[i] && (al_hour_q[i] == hour_d) && (al_min_q[i] == min_d);
      if (load_alarm && (bus.alarm_sel == AW'(i))) begin
        al_hour_d[i] = set_hour[4:0];
        al_min_d[i]  = set_min[5:0];
      end
    end
  end

`ifdef ALARM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  logic [TW-1:0] to_q, to_d;
`endif

  // Ringing/snooze state: stop beats snooze, snooze beats new sets, disabled slots always drop.
  always_comb begin
    src_d  = src_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (tick && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
`ifdef ALARM_TIMEOUT_EN
    to_d = to_q;
    if (src_q == '0) begin
      to_d = '0;
    end else if (tick) begin
      if (to_q == TW'(TIMEOUT_SEC - 1)) begin
        src_d = '0;
        to_d  = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
`endif
    if (bus.stop_al) begin
      src_d  = '0;
      mask_d = '0;
      cnt_d  = '0;
    end else if (bus.snooze && (src_q != '0)) begin
      mask_d = mask_q | src_q;
      src_d  = '0;
      cnt_d  = SNOOZE_TICKS;
    end else begin
      if (expire) begin
        src_d  = src_d | mask_q;
        mask_d = '0;
      end
      src_d = src_d | trig;
    end
    src_d  = src_d & bus.al_en;
    mask_d = mask_d & bus.al_en;
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      al_hour_q  <= '0;
      al_min_q   <= '0;
      src_q      <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      load_err_q <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
      to_q       <= '0;
`endif
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      al_hour_q  <= al_hour_d;
      al_min_q   <= al_min_d;
      src_q      <= src_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      load_err_q <= load_err_d;
`ifdef ALARM_TIMEOUT_EN
      to_q       <= to_d;
`endif
    end
  end

  assign bus.alarm_src = src_q;
  assign bus.alarm     = |src_q;
  assign bus.load_err  = load_err_q;
  assign bus.sec_tick  = tick;
  assign bus.h_out1    = 2'(hour_q / 5'd10);
  assign bus.h_out0    = 4'(hour_q % 5'd10);
  assign bus.m_out1    = 3'(min_q / 6'd10);
  assign bus.m_out0    = 4'(min_q % 6'd10);
  assign bus.s_out1    = 3'(sec_q / 6'd10);
  assign bus.s_out0    = 4'(sec_q % 6'd10);
endmodule

// File: tb/tb_rtc_multi_alarm.sv
// tb/tb_rtc_multi_alarm.sv - randomized and directed check of rtc_multi_alarm against a seconds-of-day model
module tb_rtc_multi_alarm;
  localparam int CLK_HZ     = 10;
  localparam int NA         = 5;
  localparam int SNOOZE_MIN = 1;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 0;

  // Model state: time as seconds of day, alarms as minutes of day.
  int          m_presc, m_tod, m_left;
  int          m_al [NA];
  logic [NA-1:0] m_src, m_mask;
  logic        m_err;

  rtc_multi_alarm_if #(.NUM_ALARMS(NA)) bus ();

  rtc_multi_alarm #(
    .CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .SNOOZE_MIN(SNOOZE_MIN), .TIMEOUT_SEC(5)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_tod = 0; m_left = 0;
    m_src = '0; m_mask = '0; m_err = 1'b0;
    for (int i = 0; i < NA; i++) m_al[i] = 0;
  endtask

  task automatic model_step();
    int hv, mv;
    bit valid, tick, ltime, aload;
    logic [NA-1:0] trig, en;
    if (reset) begin
      model_reset();
      return;
    end
    en    = bus.al_en;
    hv    = int'(bus.h_in1) * 10 + int'(bus.h_in0);
    mv    = int'(bus.m_in1) * 10 + int'(bus.m_in0);
    valid = (bus.h_in0 <= 9) && (bus.m_in0 <= 9) && (hv <= 23) && (mv <= 59);
    tick  = (m_presc == CLK_HZ - 1);
    ltime = bus.ld_time && valid;
    aload = !bus.ld_time && bus.ld_alarm && valid && (int'(bus.alarm_sel) < NA);
    m_err = (bus.ld_time && !valid) || (!bus.ld_time && bus.ld_alarm && !aload);
    trig  = '0;
    if (ltime) begin
      m_tod   = hv * 3600 + mv * 60;
      m_presc = 0;
    end else begin
      m_presc = tick ? 0 : m_presc + 1;
      if (tick) begin
        m_tod = (m_tod + 1) % 86400;
        if (m_tod % 60 == 0)
          for (int i = 0; i < NA; i++)
            if (en[i] && m_al[i] == m_tod / 60) trig[i] = 1'b1;
      end
    end
    if (aload) m_al[int'(bus.alarm_sel)] = hv * 60 + mv;
    if (bus.stop_al) begin
      m_src = '0; m_mask = '0; m_left = 0;
    end else if (bus.snooze && m_src != '0) begin
      m_mask = m_mask | m_src;
      m_src  = '0;
      m_left = SNOOZE_MIN * 60;
    end else begin
      if (tick && m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_src  = m_src | m_mask;
          m_mask = '0;
        end
      end
      m_src = m_src | trig;
    end
    m_src  = m_src & en;
    m_mask = m_mask & en;
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("alarm_src", 32'(bus.alarm_src), 32'(m_src));
      check("alarm", 32'(bus.alarm), 32'(m_src != '0));
      check("load_err", 32'(bus.load_err), 32'(m_err));
      check("sec_tick", 32'(bus.sec_tick), 32'(m_presc == CLK_HZ - 1));
      check("h_out1", 32'(bus.h_out1), (m_tod / 3600) / 10);
      check("h_out0", 32'(bus.h_out0), (m_tod / 3600) % 10);
      check("m_out1", 32'(bus.m_out1), ((m_tod / 60) % 60) / 10);
      check("m_out0", 32'(bus.m_out0), ((m_tod / 60) % 60) % 10);
      check("s_out1", 32'(bus.s_out1), (m_tod % 60) / 10);
      check("s_out0", 32'(bus.s_out0), (m_tod % 60) % 10);
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic set_val(input int h1, input int h0, input int m1, input int m0);
    bus.h_in1 = 2'(h1); bus.h_in0 = 4'(h0); bus.m_in1 = 3'(m1); bus.m_in0 = 4'(m0);
  endtask

  task automatic do_ld_time(input int h, input int m);
    set_val(h / 10, h % 10, m / 10, m % 10);
    bus.ld_time = 1'b1;
    cycle();
    bus.ld_time = 1'b0;
  endtask

  task automatic do_ld_alarm(input int sel, input int h, input int m);
    set_val(h / 10, h % 10, m / 10, m % 10);
    bus.alarm_sel = 3'(sel);
    bus.ld_alarm  = 1'b1;
    cycle();
    bus.ld_alarm = 1'b0;
  endtask

  initial begin
    int ticks;
    int r;
    reset = 1'b1;
    set_val(0, 0, 0, 0);
    bus.ld_time = 0; bus.ld_alarm = 0; bus.alarm_sel = '0; bus.al_en = '0;
    bus.stop_al = 0; bus.snooze = 0;
    model_reset();
    @(negedge clk);
    chk_en = 1;
    cycle();
    check("rst_alarm", 32'(bus.alarm), 0);
    check("rst_load_err", 32'(bus.load_err), 0);
    check("rst_sec_tick", 32'(bus.sec_tick), 0);
    check("rst_h_out0", 32'(bus.h_out0), 0);
    reset = 1'b0;

    // Rollover through midnight and tick cadence.
    do_ld_time(23, 59);
    ticks = 0;
    for (int k = 0; k < 600; k++) begin
      cycle();
      if (bus.sec_tick) ticks++;
    end
    check("tick_count", 32'(ticks), 60);
    check("roll_h", {bus.h_out1, bus.h_out0, bus.m_out1, bus.m_out0, bus.s_out1, bus.s_out0}, 0);

    // Trigger on slot 1 at 07:31:00.
    bus.al_en = 5'b00010;
    do_ld_alarm(1, 7, 31);
    do_ld_time(7, 30);
    run(599);
    check("pre_trig_src", 32'(bus.alarm_src), 0);
    run(1);
    check("trig_src", 32'(bus.alarm_src), 32'h2);
    check("trig_m_out0", 32'(bus.m_out0), 1);
    check("trig_s_out", {bus.s_out1, bus.s_out0}, 0);

    // Snooze one minute, re-ring, then stop for good.
    bus.snooze = 1; cycle(); bus.snooze = 0;
    check("snooze_alarm", 32'(bus.alarm), 0);
    run(598);
    check("snooze_pending", 32'(bus.alarm_src), 0);
    run(1);
    check("snooze_rering", 32'(bus.alarm_src), 32'h2);
    bus.stop_al = 1; cycle(); bus.stop_al = 0;
    check("stop_alarm", 32'(bus.alarm), 0);
    run(600);
    check("stop_no_rering", 32'(bus.alarm_src), 0);

    // Rejected loads.
    set_val(2, 4, 0, 0); bus.ld_time = 1; cycle(); bus.ld_time = 0;
    check("bad_hour_err", 32'(bus.load_err), 1);
    check("bad_hour_keep", 32'(bus.h_out0), 7);
    cycle();
    check("err_one_cycle", 32'(bus.load_err), 0);
    set_val(0, 1, 0, 10); bus.alarm_sel = 3'd0; bus.ld_alarm = 1; cycle(); bus.ld_alarm = 0;
    check("bad_digit_err", 32'(bus.load_err), 1);
    do_ld_alarm(5, 12, 0);
    check("bad_sel_err", 32'(bus.load_err), 1);
    do_ld_alarm(4, 12, 0);
    check("last_sel_ok", 32'(bus.load_err), 0);

    // stop_al on the trigger edge.
    bus.al_en = 5'b00001;
    do_ld_alarm(0, 8, 0);
    do_ld_time(7, 59);
    run(599);
    bus.stop_al = 1; cycle(); bus.stop_al = 0;
    check("stop_on_trig", 32'(bus.alarm_src), 0);
    check("stop_on_trig_h", 32'(bus.h_out0), 8);

    // ld_time with ld_alarm: only the time loads, slot 0 keeps 08:00.
    set_val(0, 9, 1, 5); bus.alarm_sel = 3'd0; bus.ld_time = 1; bus.ld_alarm = 1;
    cycle();
    bus.ld_time = 0; bus.ld_alarm = 0;
    check("both_time", {bus.h_out0, bus.m_out1, bus.m_out0}, {4'd9, 3'd1, 4'd5});
    check("both_no_err", 32'(bus.load_err), 0);
    do_ld_time(7, 59);
    run(600);
    check("slot_kept", 32'(bus.alarm_src), 32'h1);

    // Asynchronous reset while ringing.
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("arst_alarm", 32'(bus.alarm), 0);
    check("arst_src", 32'(bus.alarm_src), 0);
    check("arst_digits", {bus.h_out1, bus.h_out0, bus.m_out1, bus.m_out0, bus.s_out1, bus.s_out0}, 0);
    cycle();
    reset = 1'b0;

    // Randomized traffic around 12:00-12:05.
    bus.al_en = '1;
    do_ld_time(12, 0);
    for (int c = 0; c < 20000; c++) begin
      r = int'($urandom_range(0, 999));
      bus.ld_time  = (r < 3);
      bus.ld_alarm = (r == 0) || (r >= 3 && r < 15);
      bus.snooze   = (r >= 15 && r < 20);
      bus.stop_al  = (r == 20);
      if (r == 21) bus.al_en = 5'($urandom);
      if (bus.ld_time || bus.ld_alarm) begin
        if ($urandom_range(0, 7) == 0)
          set_val(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        else
          set_val(1, 2, 0, int'($urandom_range(0, 5)));
        bus.alarm_sel = 3'($urandom_range(0, 7));
      end
      cycle();
    end
    bus.ld_time = 0; bus.ld_alarm = 0; bus.snooze = 0; bus.stop_al = 0;
    run(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
